// File: rtl/axi_led_regs.sv
// AXI4 responder exposing LED override, scratch and cycle-counter registers.
// Independent write and read FSMs; INCR/FIXED bursts, WRAP treated as INCR.
module axi_led_regs #(
   parameter int ID_W   = 16,
   parameter int ADDR_W = 40,
   parameter int DATA_W = 128
) (
   input  logic                pl_clk,
   input  logic                pl_resetn,
   input  logic [ID_W-1:0]     s_awid,
   input  logic [ADDR_W-1:0]   s_awaddr,
   input  logic [7:0]          s_awlen,
   input  logic [1:0]          s_awburst,
   input  logic                s_awvalid,
   output logic                s_awready,
   input  logic [DATA_W-1:0]   s_wdata,
   input  logic [DATA_W/8-1:0] s_wstrb,
   input  logic                s_wlast,
   input  logic                s_wvalid,
   output logic                s_wready,
   output logic [ID_W-1:0]     s_bid,
   output logic [1:0]          s_bresp,
   output logic                s_bvalid,
   input  logic                s_bready,
   input  logic [ID_W-1:0]     s_arid,
   input  logic [ADDR_W-1:0]   s_araddr,
   input  logic [7:0]          s_arlen,
   input  logic [1:0]          s_arburst,
   input  logic                s_arvalid,
   output logic                s_arready,
   output logic [ID_W-1:0]     s_rid,
   output logic [DATA_W-1:0]   s_rdata,
   output logic [1:0]          s_rresp,
   output logic                s_rlast,
   output logic                s_rvalid,
   input  logic                s_rready,
   output logic                led_override,
   output logic [7:0]          led_value
);

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   wstate_t ws, ws_n;
   rstate_t rs, rs_n;

   logic              live;
   logic [31:0]       scratch;
   logic [31:0]       cycles;

   logic [ID_W-1:0]   w_id;
   logic [ADDR_W-1:0] w_addr;
   logic [7:0]        w_len;
   logic [7:0]        w_cnt;
   logic              w_fixed;
   logic              w_err;
   logic              aw_hs, w_hs, b_hs;
   logic              w_ok, w_last_beat;

   logic [ID_W-1:0]   r_id;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_len;
   logic [7:0]        r_cnt;
   logic              r_fixed;
   logic [31:0]       r_data;
   logic [1:0]        r_resp;
   logic              r_last;
   logic              ar_hs, r_hs, load;
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_ok, ld_last;
   logic [1:0]        ld_idx;
   logic [31:0]       ld_data;
   logic [1:0]        ld_resp;

   logic              unused;
   assign unused = ^{s_wdata[DATA_W-1:32], s_wstrb[DATA_W/8-1:4]};

   // Holds ready outputs low for the first cycle after reset release.
   always_ff @(posedge pl_clk or negedge pl_resetn) begin
      if (!pl_resetn) live <= 1'b0;
      else            live <= 1'b1;
   end

   always_ff @(posedge pl_clk or negedge pl_resetn) begin
      if (!pl_resetn) cycles <= '0;
      else            cycles <= cycles + 32'd1;
   end

   // ---------------- write channel ----------------
   assign aw_hs       = s_awvalid && s_awready;
   assign w_hs        = s_wvalid && s_wready;
   assign b_hs        = s_bvalid && s_bready;
   assign w_ok        = (w_addr[ADDR_W-1:6] == '0);
   assign w_last_beat = (w_cnt == w_len);

   always_ff @(posedge pl_clk or negedge pl_resetn) begin
      if (!pl_resetn) ws <= W_IDLE;
      else            ws <= ws_n;
   end

   always_comb begin
      ws_n = ws;
      unique case (ws)
         W_IDLE: if (aw_hs) ws_n = W_DATA;
         W_DATA: if (w_hs && w_last_beat) ws_n = W_RESP;
         W_RESP: if (b_hs) ws_n = W_IDLE;
         default: ws_n = W_IDLE;
      endcase
   end

   always_comb begin
      s_awready = live && (ws == W_IDLE);
      s_wready  = (ws == W_DATA);
      s_bvalid  = (ws == W_RESP);
      s_bid     = w_id;
      s_bresp   = w_err ? SLVERR : OKAY;
   end

   always_ff @(posedge pl_clk or negedge pl_resetn) begin
      if (!pl_resetn) begin
         w_id    <= '0;
         w_addr  <= '0;
         w_len   <= '0;
         w_cnt   <= '0;
         w_fixed <= 1'b0;
         w_err   <= 1'b0;
      end else if (aw_hs) begin
         w_id    <= s_awid;
         w_addr  <= s_awaddr;
         w_len   <= s_awlen;
         w_cnt   <= '0;
         w_fixed <= (s_awburst == 2'b00);
         w_err   <= 1'b0;
      end else if (w_hs) begin
         w_cnt <= w_cnt + 8'd1;
         if (!w_fixed) w_addr <= w_addr + ADDR_W'(16);
         if (!w_ok || (s_wlast != w_last_beat)) w_err <= 1'b1;
      end
   end

   always_ff @(posedge pl_clk or negedge pl_resetn) begin
      if (!pl_resetn) begin
         led_override <= 1'b0;
         led_value    <= '0;
         scratch      <= '0;
      end else if (w_hs && w_ok) begin
         unique case (w_addr[5:4])
            2'd0: if (s_wstrb[0]) led_override <= s_wdata[0];
            2'd1: if (s_wstrb[0]) led_value <= s_wdata[7:0];
            2'd2: begin
               for (int b = 0; b < 4; b++)
                  if (s_wstrb[b]) scratch[8*b +: 8] <= s_wdata[8*b +: 8];
            end
            2'd3: ;
            default: ;
         endcase
      end
   end

   // ---------------- read channel ----------------
   assign ar_hs   = s_arvalid && s_arready;
   assign r_hs    = s_rvalid && s_rready;
   assign load    = ar_hs || (r_hs && !r_last);
   assign ld_addr = (rs == R_IDLE) ? s_araddr :
                    (r_fixed ? r_addr : r_addr + ADDR_W'(16));
   assign ld_ok   = (ld_addr[ADDR_W-1:6] == '0);
   assign ld_idx  = ld_addr[5:4];
   assign ld_last = (rs == R_IDLE) ? (s_arlen == 8'd0) :
                    (r_cnt + 8'd1 == r_len);

   always_comb begin
      ld_data = '0;
      ld_resp = OKAY;
      unique case (1'b1)
         !ld_ok:                  ld_resp = SLVERR;
         ld_ok && ld_idx == 2'd0: ld_data = {31'b0, led_override};
         ld_ok && ld_idx == 2'd1: ld_data = {24'b0, led_value};
         ld_ok && ld_idx == 2'd2: ld_data = scratch;
         ld_ok && ld_idx == 2'd3: ld_data = cycles;
         default: ;
      endcase
   end

   always_ff @(posedge pl_clk or negedge pl_resetn) begin
      if (!pl_resetn) rs <= R_IDLE;
      else            rs <= rs_n;
   end

   always_comb begin
      rs_n = rs;
      unique case (rs)
         R_IDLE: if (ar_hs) rs_n = R_DATA;
         R_DATA: if (r_hs && r_last) rs_n = R_IDLE;
         default: rs_n = R_IDLE;
      endcase
   end

   always_comb begin
      s_arready = live && (rs == R_IDLE);
      s_rvalid  = (rs == R_DATA);
      s_rid     = r_id;
      s_rdata   = DATA_W'(r_data);
      s_rresp   = r_resp;
      s_rlast   = r_last;
   end

   always_ff @(posedge pl_clk or negedge pl_resetn) begin
      if (!pl_resetn) begin
         r_id    <= '0;
         r_len   <= '0;
         r_fixed <= 1'b0;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_resp  <= OKAY;
         r_last  <= 1'b0;
      end else begin
         if (ar_hs) begin
            r_id    <= s_arid;
            r_len   <= s_arlen;
            r_fixed <= (s_arburst == 2'b00);
            r_cnt   <= '0;
         end else if (r_hs && !r_last) begin
            r_cnt <= r_cnt + 8'd1;
         end
         if (load) begin
            r_addr <= ld_addr;
            r_data <= ld_data;
            r_resp <= ld_resp;
            r_last <= ld_last;
         end
      end
   end

endmodule

// File: tb/tb_axi_led_regs.sv
// Randomized scoreboard bench for axi_led_regs.
// Expected B/R responses are queued at issue and checked by a monitor.
module tb_axi_led_regs;

   localparam int ID_W   = 16;
   localparam int ADDR_W = 40;
   localparam int DATA_W = 128;

   logic                pl_clk = 1'b0;
   logic                pl_resetn = 1'b0;
   logic [ID_W-1:0]     s_awid = '0;
   logic [ADDR_W-1:0]   s_awaddr = '0;
   logic [7:0]          s_awlen = '0;
   logic [1:0]          s_awburst = '0;
   logic                s_awvalid = 1'b0;
   logic                s_awready;
   logic [DATA_W-1:0]   s_wdata = '0;
   logic [DATA_W/8-1:0] s_wstrb = '0;
   logic                s_wlast = 1'b0;
   logic                s_wvalid = 1'b0;
   logic                s_wready;
   logic [ID_W-1:0]     s_bid;
   logic [1:0]          s_bresp;
   logic                s_bvalid;
   logic                s_bready = 1'b0;
   logic [ID_W-1:0]     s_arid = '0;
   logic [ADDR_W-1:0]   s_araddr = '0;
   logic [7:0]          s_arlen = '0;
   logic [1:0]          s_arburst = '0;
   logic                s_arvalid = 1'b0;
   logic                s_arready;
   logic [ID_W-1:0]     s_rid;
   logic [DATA_W-1:0]   s_rdata;
   logic [1:0]          s_rresp;
   logic                s_rlast;
   logic                s_rvalid;
   logic                s_rready = 1'b0;
   logic                led_override;
   logic [7:0]          led_value;

   axi_led_regs #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .pl_clk(pl_clk), .pl_resetn(pl_resetn),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
      .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
      .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
      .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .led_override(led_override), .led_value(led_value)
   );

   always #5 pl_clk = ~pl_clk;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [1:0]      resp;
   } bexp_t;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [31:0]     data;
      logic [1:0]      resp;
      logic            last;
      bit              is_cyc;
      int unsigned     lo;
   } rexp_t;

   bexp_t bq[$];
   rexp_t rq[$];

   int n_chk = 0;
   int n_fail = 0;

   // reference state: register file and elapsed clock count since reset
   logic        m_ctrl = 1'b0;
   logic [7:0]  m_led = '0;
   logic [31:0] m_scratch = '0;
   int unsigned cyc_m = 0;

   int bmode = 0;
   int rmode = 0;

   always @(posedge pl_clk or negedge pl_resetn)
      if (!pl_resetn) cyc_m <= 0;
      else            cyc_m <= cyc_m + 1;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(posedge pl_clk) begin
      #1;
      s_bready = (bmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      unique case (rmode)
         0: s_rready = 1'b1;
         1: s_rready = 1'($urandom_range(0, 1));
         2: s_rready = !s_rready;
         default: s_rready = 1'b0;
      endcase
   end

   // monitor: pops expectations on every handshake, checks R stability
   logic        hold_v = 1'b0;
   logic [127:0] hold_d;
   logic [18:0] hold_c;

   always @(negedge pl_clk) begin
      bexp_t be;
      rexp_t re;
      if (!pl_resetn) begin
         hold_v = 1'b0;
      end else begin
         if (s_bvalid && s_bready) begin
            if (bq.size() == 0) chk("b_unexpected", 1, 0);
            else begin
               be = bq.pop_front();
               chk("bid", s_bid, be.id);
               chk("bresp", s_bresp, be.resp);
            end
         end
         if (hold_v && s_rvalid) begin
            chk("r_stall_data", s_rdata, hold_d);
            chk("r_stall_ctl", {s_rid, s_rresp, s_rlast}, hold_c);
         end
         if (s_rvalid && s_rready) begin
            if (rq.size() == 0) chk("r_unexpected", 1, 0);
            else begin
               re = rq.pop_front();
               chk("rid", s_rid, re.id);
               chk("rresp", s_rresp, re.resp);
               chk("rlast", s_rlast, re.last);
               if (re.is_cyc) begin
                  chk("r_cycles_hi", s_rdata[127:32], 0);
                  chk("r_cycles_window",
                      (s_rdata[31:0] >= re.lo) && (s_rdata[31:0] < cyc_m), 1);
               end else begin
                  chk("rdata", s_rdata, {96'b0, re.data});
               end
            end
         end
         hold_v = s_rvalid && !s_rready;
         hold_d = s_rdata;
         hold_c = {s_rid, s_rresp, s_rlast};
      end
   end

   task automatic align();
      @(posedge pl_clk);
      #1;
   endtask

   task automatic wait_hi(input int which, input string nm);
      for (int t = 0; t < 200; t++) begin
         @(negedge pl_clk);
         if (which == 0 && s_awready) return;
         if (which == 1 && s_wready) return;
         if (which == 2 && s_arready) return;
      end
      chk(nm, 0, 1);
   endtask

   task automatic drain(input string nm);
      for (int t = 0; t < 400; t++) begin
         if (bq.size() == 0 && rq.size() == 0) return;
         @(negedge pl_clk);
      end
      chk(nm, 0, 1);
      bq.delete();
      rq.delete();
   endtask

   function automatic logic [ADDR_W-1:0] beat_addr(
         input logic [ADDR_W-1:0] base, input logic [1:0] burst, input int i);
      return (burst == 2'b00) ? base : base + ADDR_W'(16 * i);
   endfunction

   task automatic do_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input int len, input logic [1:0] burst,
                           input logic [3:0][31:0] d, input logic [3:0][3:0] st,
                           input bit bad_last);
      bit err = bad_last;
      logic [ADDR_W-1:0] a;
      for (int i = 0; i <= len; i++) begin
         a = beat_addr(addr, burst, i);
         if (a >= 40'h40) err = 1;
         else if (a[5:4] == 2'd0) begin
            if (st[i][0]) m_ctrl = d[i][0];
         end else if (a[5:4] == 2'd1) begin
            if (st[i][0]) m_led = d[i][7:0];
         end else if (a[5:4] == 2'd2) begin
            for (int b = 0; b < 4; b++)
               if (st[i][b]) m_scratch[8*b +: 8] = d[i][8*b +: 8];
         end
      end
      bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
      align();
      s_awid = id; s_awaddr = addr; s_awlen = 8'(len); s_awburst = burst;
      s_awvalid = 1'b1;
      wait_hi(0, "aw_timeout");
      align();
      s_awvalid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         repeat ($urandom_range(0, 1)) align();
         s_wdata = {$urandom, $urandom, $urandom, d[i]};
         s_wstrb = {12'($urandom), st[i]};
         s_wlast = (i == len) ? !bad_last : 1'b0;
         s_wvalid = 1'b1;
         wait_hi(1, "w_timeout");
         align();
         s_wvalid = 1'b0;
      end
      chk("led_override_after_w", led_override, m_ctrl);
      chk("led_value_after_w", led_value, m_led);
      drain("b_timeout");
   endtask

   task automatic do_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input int len, input logic [1:0] burst);
      logic [ADDR_W-1:0] a;
      rexp_t e;
      for (int i = 0; i <= len; i++) begin
         a = beat_addr(addr, burst, i);
         e = '{id: id, data: 32'h0, resp: 2'b00, last: (i == len),
               is_cyc: 1'b0, lo: cyc_m};
         if (a >= 40'h40) e.resp = 2'b10;
         else if (a[5:4] == 2'd0) e.data = {31'b0, m_ctrl};
         else if (a[5:4] == 2'd1) e.data = {24'b0, m_led};
         else if (a[5:4] == 2'd2) e.data = m_scratch;
         else e.is_cyc = 1'b1;
         rq.push_back(e);
      end
      align();
      s_arid = id; s_araddr = addr; s_arlen = 8'(len); s_arburst = burst;
      s_arvalid = 1'b1;
      wait_hi(2, "ar_timeout");
      align();
      s_arvalid = 1'b0;
      drain("r_timeout");
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ADDR_W-1:0] ra;
      logic [3:0][31:0] rd;
      logic [3:0][3:0]  rs;

      #1;
      chk("rst_awready", s_awready, 0);
      chk("rst_arready", s_arready, 0);
      chk("rst_bvalid", s_bvalid, 0);
      chk("rst_rvalid", s_rvalid, 0);
      chk("rst_wready", s_wready, 0);
      chk("rst_leds", {led_override, led_value}, 0);
      repeat (3) @(negedge pl_clk);
      pl_resetn = 1'b1;

      do_write(16'h1234, 40'h10, 0, 2'b01, {32'h0, 32'h0, 32'h0, 32'hA5},
               {4'h0, 4'h0, 4'h0, 4'h1}, 0);
      do_write(16'h0002, 40'h00, 3, 2'b01,
               {32'h55, 32'hDEADBEEF, 32'h3C, 32'h1},
               {4'hF, 4'hF, 4'hF, 4'hF}, 0);
      rmode = 2;
      do_read(16'h0003, 40'h20, 1, 2'b01);
      rmode = 0;
      do_write(16'h0004, 40'h30, 1, 2'b01, {32'h0, 32'h0, 32'hFF, 32'hFF},
               {4'h0, 4'h0, 4'hF, 4'hF}, 0);
      do_read(16'h0005, 40'h40, 0, 2'b01);
      do_write(16'h0006, 40'h20, 0, 2'b01, {32'h0, 32'h0, 32'h0, 32'h11223344},
               {4'h0, 4'h0, 4'h0, 4'h6}, 0);
      do_read(16'h0007, 40'h20, 0, 2'b01);
      do_read(16'h0008, 40'h00, 3, 2'b00);

      for (int n = 0; n < 60; n++) begin
         bmode = $urandom_range(0, 1);
         rmode = $urandom_range(0, 1);
         ra = ADDR_W'(16 * $urandom_range(0, 5));
         if ($urandom_range(0, 9) == 0) ra[20] = 1'b1;
         for (int i = 0; i < 4; i++) begin
            rd[i] = $urandom;
            rs[i] = 4'($urandom);
         end
         if ($urandom_range(0, 1) == 1)
            do_write(16'($urandom), ra, $urandom_range(0, 3),
                     2'($urandom_range(0, 2)), rd, rs,
                     $urandom_range(0, 7) == 0);
         else
            do_read(16'($urandom), ra, $urandom_range(0, 3),
                    2'($urandom_range(0, 2)));
      end
      bmode = 0;

      // reset in the middle of a stalled read burst
      rmode = 3;
      align();
      s_arid = 16'h00AA; s_araddr = 40'h00; s_arlen = 8'd3; s_arburst = 2'b01;
      s_arvalid = 1'b1;
      wait_hi(2, "ar_timeout_rst");
      align();
      s_arvalid = 1'b0;
      repeat (2) @(posedge pl_clk);
      #2;
      pl_resetn = 1'b0;
      #1;
      chk("midrst_rvalid", s_rvalid, 0);
      chk("midrst_arready", s_arready, 0);
      chk("midrst_leds", {led_override, led_value}, 0);
      bq.delete();
      rq.delete();
      m_ctrl = 1'b0;
      m_led = '0;
      m_scratch = '0;
      repeat (2) @(negedge pl_clk);
      pl_resetn = 1'b1;
      rmode = 0;
      do_read(16'h00BB, 40'h00, 3, 2'b01);
      do_read(16'h00CC, 40'h20, 0, 2'b01);

      drain("final_drain");
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
